// File: rtl/random_pkg.sv
// Shared constants and LFSR helper functions for the random code generator.
package random_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 8;

  // Maximal-length Fibonacci tap masks, right-aligned in an 8-bit field.
  function automatic logic [7:0] tap_mask(input int w);
    logic [7:0] m;
    case (w)
      3:       m = 8'h06;
      4:       m = 8'h0C;
      5:       m = 8'h14;
      6:       m = 8'h30;
      7:       m = 8'h60;
      8:       m = 8'hB8;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
  // Bits above w are cleared so the result is a clean w-bit state.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q, input int w);
    logic [7:0] width_mask;
    logic       fb;
    width_mask = 8'hFF >> (8 - w);
    fb         = ^(q & tap_mask(w));
    return {q[6:0], fb} & width_mask;
  endfunction

endpackage

// File: rtl/random_lfsr_core.sv
// LFSR state register with synchronous preset and optional all-zero recovery.
// Optional feature macro: RANDOM_LOCKUP_GUARD_EN (all-zero state reloads a nonzero value).
module random_lfsr_core
  import random_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_s;
  logic [7:0]       q_ext_s;
  logic [7:0]       shifted_s;
  logic             unused_shift_s;

  // Zero-extend the state into the 8-bit domain the helper functions use.
  always_comb begin
    q_ext_s             = 8'h00;
    q_ext_s[WIDTH-1:0]  = q_r;
  end

  assign shifted_s      = lfsr_next(q_ext_s, WIDTH);
  assign unused_shift_s = ^shifted_s;

  // Select the next state: normal shift, or recovery out of the all-zero state.
  always_comb begin
    next_s = shifted_s[WIDTH-1:0];
`ifdef RANDOM_LOCKUP_GUARD_EN
    if (q_r == '0) begin
      if (seed != '0) begin
        next_s = seed;
      end else begin
        next_s = {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      next_s = shifted_s[WIDTH-1:0];
    end
`endif
  end

  // State register: preset loads the seed, otherwise the LFSR advances every edge.
  always_ff @(posedge clk) begin
    if (preset) begin
      q_r <= seed;
    end else begin
      q_r <= next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/random_code_gen.sv
// Free-running pseudo-random code generator (Fibonacci LFSR, one step per clk).
// Optional feature macro: RANDOM_LOCKUP_GUARD_EN (allows SEED=0, recovers from all-zero).
module random_code_gen
  import random_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             preset,
  output logic [WIDTH-1:0] code
);

  // Reject unsupported widths and an all-zero seed that would lock the LFSR.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("random_code_gen: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
`ifndef RANDOM_LOCKUP_GUARD_EN
  if (SEED == '0) begin : g_bad_seed
    $error("random_code_gen: SEED must be nonzero without the lockup guard");
  end
`endif

  logic [WIDTH-1:0] q_s;

  random_lfsr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .preset (preset),
    .seed   (SEED),
    .q      (q_s)
  );

  // The code is the register state itself, with no logic between flops and port.
  assign code = q_s;

endmodule

// File: tb/tb_random_code_gen.sv
// Directed self-checking bench for random_code_gen (WIDTH=4).
module tb_random_code_gen;

  logic       clk;
  logic       preset_a;
  logic       preset_b;
  logic [3:0] code_a;
  logic [3:0] code_b;
  int         compared;
  int         mismatched;
  int         counts [16];
  logic [3:0] seq_a [16];
  logic [3:0] seq_b [3];
  int         budget;

  random_code_gen #(.WIDTH(4), .SEED(4'h1)) dut_a (
    .clk(clk), .preset(preset_a), .code(code_a)
  );

  random_code_gen #(.WIDTH(4), .SEED(4'h9)) dut_b (
    .clk(clk), .preset(preset_b), .code(code_b)
  );

`ifdef RANDOM_LOCKUP_GUARD_EN
  logic       preset_c;
  logic [3:0] code_c;
  random_code_gen #(.WIDTH(4), .SEED(4'h0)) dut_c (
    .clk(clk), .preset(preset_c), .code(code_c)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    seq_a = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2};
    seq_b = '{4'h3, 4'h6, 4'hD};
    preset_a = 1'b1;
    preset_b = 1'b1;
`ifdef RANDOM_LOCKUP_GUARD_EN
    preset_c = 1'b1;
`endif

    // 1: preset held for 6 edges
    for (int i = 0; i < 6; i++) begin
      step();
      check("preset_hold_a", code_a, 4'h1);
      check("preset_hold_b", code_b, 4'h9);
`ifdef RANDOM_LOCKUP_GUARD_EN
      check("preset_hold_c", code_c, 4'h0);
`endif
    end

    // 2: release, 16 edges of the known sequence
    preset_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("sequence", code_a, seq_a[i]);
    end

    // 3: 30 edges, every nonzero value twice, zero never
    for (int i = 0; i < 16; i++) counts[i] = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      counts[code_a]++;
    end
    check_int("zero_count", counts[0], 0);
    for (int v = 1; v < 16; v++) begin
      check_int("value_count", counts[v], 2);
    end
    check("period_return", code_a, 4'h2);

    // 4: preset at code==B restarts the sequence from the seed
    budget = 0;
    while (code_a !== 4'hB && budget < 20) begin
      step();
      budget++;
    end
    check("reach_B", code_a, 4'hB);
    preset_a = 1'b1;
    step();
    check("midseq_preset", code_a, 4'h1);
    preset_a = 1'b0;
    step();
    check("restart_1", code_a, 4'h2);
    step();
    check("restart_2", code_a, 4'h4);
    step();
    check("restart_3", code_a, 4'h9);

    // 5: SEED=9 instance enters the ring at a different phase
    check("seed9_start", code_b, 4'h9);
    preset_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("seed9_seq", code_b, seq_b[i]);
    end

    // 6: all-zero state behaviour
    force dut_a.u_core.q_r = 4'h0;
    #1;
    release dut_a.u_core.q_r;
    #1;
    check("forced_zero", code_a, 4'h0);
`ifdef RANDOM_LOCKUP_GUARD_EN
    step();
    check("guard_recover", code_a, 4'h1);
    step();
    check("guard_next1", code_a, 4'h2);
    step();
    check("guard_next2", code_a, 4'h4);
    preset_c = 1'b0;
    step();
    check("seed0_recover", code_c, 4'h1);
    step();
    check("seed0_next1", code_c, 4'h2);
    step();
    check("seed0_next2", code_c, 4'h4);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      check("lockup_stays_zero", code_a, 4'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
